// File: rtl/bias_buffer_ctrl_pkg.sv
// bias_buffer_ctrl_pkg: state encodings and row/bank-group geometry for the bias buffer sequencer.
package bias_buffer_ctrl_pkg;

    typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_DONE} ld_state_e;
    typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_DRAIN} rd_state_e;

    function automatic int beats_per_row(input int ddr_bw, input int banks, input int ww);
        return (banks * ww / ddr_bw) < 1 ? 1 : banks * ww / ddr_bw;
    endfunction

    // A beat wider than a whole row still only covers every bank once.
    function automatic int group_size(input int ddr_bw, input int banks, input int ww);
        return (ddr_bw / ww) > banks ? banks : ddr_bw / ww;
    endfunction

endpackage

// File: rtl/bias_rd_valid_pipe.sv
// bias_rd_valid_pipe: DEPTH-stage valid shift register matching the bank read latency.
// empty is high when nothing is left upstream of the output stage.
module bias_rd_valid_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic in_valid,
    output logic out_valid,
    output logic empty
);
    logic [DEPTH-1:0] sr_q, sr_d;
    logic [DEPTH:0]   pend;

    assign pend      = {sr_q, in_valid};
    assign out_valid = sr_q[DEPTH-1];
    assign empty     = ~|pend[DEPTH-1:0];

    always_comb begin
        sr_d = clr ? '0 : pend[DEPTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sr_q <= '0;
        else       sr_q <= sr_d;
    end
endmodule

// File: rtl/bias_buffer_ctrl.sv
// bias_buffer_ctrl: load engine slicing DDR beats across bank groups, read engine issuing lockstep row reads.
// Define BIAS_BUF_CTRL_RAW_GUARD_EN to hold reads of rows the active load has not yet written.
module bias_buffer_ctrl
    import bias_buffer_ctrl_pkg::*;
#(
    parameter int DDR_BANDWIDTH    = 512,
    parameter int NUM_BANKS        = 64,
    parameter int WRITE_WIDTH      = 8,
    parameter int READ_WIDTH       = 8,
    parameter int WRITE_ADDR_WIDTH = 8,
    parameter int READ_ADDR_WIDTH  = 8,
    parameter int READ_LATENCY_B   = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  ld_start,
    input  logic [WRITE_ADDR_WIDTH-1:0]           ld_base,
    input  logic [WRITE_ADDR_WIDTH:0]             ld_rows,
    input  logic                                  ddr_valid,
    input  logic [DDR_BANDWIDTH-1:0]              ddr_data,
    output logic                                  ddr_ready,
    output logic                                  ld_busy,
    output logic                                  ld_done,
    input  logic                                  rd_start,
    input  logic [READ_ADDR_WIDTH-1:0]            rd_base,
    input  logic [READ_ADDR_WIDTH:0]              rd_rows,
    input  logic                                  rd_stall,
    output logic                                  rd_busy,
    output logic                                  rd_done,
    output logic                                  bias_valid,
    output logic [NUM_BANKS-1:0]                  bs_write_req,
    output logic [NUM_BANKS*WRITE_ADDR_WIDTH-1:0] bs_write_addr,
    output logic [DDR_BANDWIDTH-1:0]              bs_write_data,
    output logic [NUM_BANKS-1:0]                  bs_read_req,
    output logic [NUM_BANKS*READ_ADDR_WIDTH-1:0]  bs_read_addr
);
    localparam int BPR = beats_per_row(DDR_BANDWIDTH, NUM_BANKS, WRITE_WIDTH);
    localparam int G   = group_size(DDR_BANDWIDTH, NUM_BANKS, WRITE_WIDTH);
    localparam int BW  = BPR > 1 ? $clog2(BPR) : 1;
    localparam int WA  = WRITE_ADDR_WIDTH;
    localparam int RA  = READ_ADDR_WIDTH;

    ld_state_e               ld_state_q, ld_state_d;
    logic [WA-1:0]           ld_base_q, ld_base_d, wr_row;
    logic [WA:0]             ld_rows_q, ld_rows_d, row_q, row_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic                    ld_done_q, ld_done_d, last_beat;
    logic [NUM_BANKS-1:0]    wr_req_q, wr_req_d;
    logic [NUM_BANKS*WA-1:0] wr_addr_q, wr_addr_d;
    logic [DDR_BANDWIDTH-1:0] wr_data_q, wr_data_d;

    rd_state_e               rd_state_q, rd_state_d;
    logic [RA-1:0]           rd_base_q, rd_base_d, rd_row, rd_addr_q, rd_addr_d;
    logic [RA:0]             rd_rows_q, rd_rows_d, idx_q, idx_d;
    logic                    rd_req_q, rd_req_d, rd_done_q, rd_done_d;
    logic                    issue, raw_hold, pipe_empty;

    assign wr_row        = ld_base_q + row_q[WA-1:0];
    assign last_beat     = beat_q == BW'(BPR - 1);
    assign rd_row        = rd_base_q + idx_q[RA-1:0];
    assign ddr_ready     = ld_state_q == LD_LOAD;
    assign ld_busy       = ld_state_q != LD_IDLE;
    assign ld_done       = ld_done_q;
    assign rd_busy       = rd_state_q != RD_IDLE;
    assign rd_done       = rd_done_q;
    assign bs_write_req  = wr_req_q;
    assign bs_write_addr = wr_addr_q;
    assign bs_write_data = wr_data_q;
    assign bs_read_req   = {NUM_BANKS{rd_req_q}};
    assign bs_read_addr  = {NUM_BANKS{rd_addr_q}};

`ifdef BIAS_BUF_CTRL_RAW_GUARD_EN
    logic [WA-1:0] raw_off;
    // Row offset into the load window; only rows the load has not finished are held.
    assign raw_off  = WA'(rd_row) - ld_base_q;
    assign raw_hold = ld_busy && ({1'b0, raw_off} < ld_rows_q) && (row_q <= {1'b0, raw_off});
`else
    assign raw_hold = 1'b0;
`endif

    assign issue = rd_state_q == RD_ISSUE && !rd_stall && !raw_hold;

    always_comb begin
        ld_state_d = ld_state_q;
        ld_base_d  = ld_base_q;
        ld_rows_d  = ld_rows_q;
        beat_d     = beat_q;
        row_d      = row_q;
        ld_done_d  = 1'b0;
        wr_req_d   = '0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (ld_state_q == LD_IDLE && ld_start) begin
            ld_done_d  = ld_rows == '0;
            ld_state_d = ld_rows == '0 ? LD_IDLE : LD_LOAD;
            ld_base_d  = ld_base;
            ld_rows_d  = ld_rows;
            beat_d     = '0;
            row_d      = '0;
        end else if (ld_state_q == LD_LOAD && ddr_valid) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (b / G == int'(beat_q)) begin
                    wr_req_d[b]           = 1'b1;
                    wr_addr_d[b*WA +: WA] = wr_row;
                end
            end
            wr_data_d  = ddr_data;
            beat_d     = last_beat ? '0 : beat_q + 1'b1;
            row_d      = last_beat ? row_q + 1'b1 : row_q;
            ld_state_d = last_beat && row_q == ld_rows_q - 1'b1 ? LD_DONE : LD_LOAD;
        end else if (ld_state_q == LD_DONE) begin
            ld_done_d  = 1'b1;
            ld_state_d = LD_IDLE;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_base_d  = rd_base_q;
        rd_rows_d  = rd_rows_q;
        rd_done_d  = 1'b0;
        rd_req_d   = issue;
        rd_addr_d  = issue ? rd_row : rd_addr_q;
        idx_d      = issue ? idx_q + 1'b1 : idx_q;
        if (rd_state_q == RD_IDLE && rd_start) begin
            rd_done_d  = rd_rows == '0;
            rd_state_d = rd_rows == '0 ? RD_IDLE : RD_ISSUE;
            rd_base_d  = rd_base;
            rd_rows_d  = rd_rows;
            idx_d      = '0;
        end else if (issue && idx_q == rd_rows_q - 1'b1) begin
            rd_state_d = RD_DRAIN;
        end else if (rd_state_q == RD_DRAIN && pipe_empty) begin
            rd_done_d  = 1'b1;
            rd_state_d = RD_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_state_q <= LD_IDLE;
            ld_base_q  <= '0;
            ld_rows_q  <= '0;
            beat_q     <= '0;
            row_q      <= '0;
            ld_done_q  <= 1'b0;
            wr_req_q   <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_state_q <= RD_IDLE;
            rd_base_q  <= '0;
            rd_rows_q  <= '0;
            idx_q      <= '0;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= '0;
            rd_done_q  <= 1'b0;
        end else begin
            ld_state_q <= ld_state_d;
            ld_base_q  <= ld_base_d;
            ld_rows_q  <= ld_rows_d;
            beat_q     <= beat_d;
            row_q      <= row_d;
            ld_done_q  <= ld_done_d;
            wr_req_q   <= wr_req_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_state_q <= rd_state_d;
            rd_base_q  <= rd_base_d;
            rd_rows_q  <= rd_rows_d;
            idx_q      <= idx_d;
            rd_req_q   <= rd_req_d;
            rd_addr_q  <= rd_addr_d;
            rd_done_q  <= rd_done_d;
        end
    end

    // Idle clear flushes any stragglers so a new read never sees stale valids.
    bias_rd_valid_pipe #(.DEPTH(READ_LATENCY_B)) u_valid_pipe (
        .clk       (clk),
        .reset     (reset),
        .clr       (rd_state_q == RD_IDLE),
        .in_valid  (rd_req_q),
        .out_valid (bias_valid),
        .empty     (pipe_empty)
    );
endmodule

// File: tb/tb_bias_buffer_ctrl.sv
// tb_bias_buffer_ctrl: directed and randomized checks of bias_buffer_ctrl against a count-based reference model.
module tb_bias_buffer_ctrl;
    localparam int DDR = 256, NB = 64, WW = 8, AW = 8, RAW = 8, L = 2;
    localparam int G = DDR / WW;
    localparam int BPR = NB * WW / DDR;

    logic clk = 1'b0, reset = 1'b0;
    logic ld_start = 1'b0, ddr_valid = 1'b0, rd_start = 1'b0, rd_stall = 1'b0;
    logic [AW-1:0] ld_base = '0;
    logic [AW:0] ld_rows = '0;
    logic [DDR-1:0] ddr_data = '0;
    logic [RAW-1:0] rd_base = '0;
    logic [RAW:0] rd_rows = '0;
    logic ddr_ready, ld_busy, ld_done, rd_busy, rd_done, bias_valid;
    logic [NB-1:0] bs_write_req, bs_read_req;
    logic [NB*AW-1:0] bs_write_addr;
    logic [NB*RAW-1:0] bs_read_addr;
    logic [DDR-1:0] bs_write_data;

    bias_buffer_ctrl #(
        .DDR_BANDWIDTH(DDR), .NUM_BANKS(NB), .WRITE_WIDTH(WW), .READ_WIDTH(8),
        .WRITE_ADDR_WIDTH(AW), .READ_ADDR_WIDTH(RAW), .READ_LATENCY_B(L)
    ) dut (
        .clk(clk), .reset(reset), .ld_start(ld_start), .ld_base(ld_base), .ld_rows(ld_rows),
        .ddr_valid(ddr_valid), .ddr_data(ddr_data), .ddr_ready(ddr_ready), .ld_busy(ld_busy),
        .ld_done(ld_done), .rd_start(rd_start), .rd_base(rd_base), .rd_rows(rd_rows),
        .rd_stall(rd_stall), .rd_busy(rd_busy), .rd_done(rd_done), .bias_valid(bias_valid),
        .bs_write_req(bs_write_req), .bs_write_addr(bs_write_addr), .bs_write_data(bs_write_data),
        .bs_read_req(bs_read_req), .bs_read_addr(bs_read_addr)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int ld_act, ld_cnt, ld_total, ld_rows_m, rd_act, rd_idx, rd_total, rd_timer;
    int ld_base_m, rd_base_m;
    logic e_ready, e_ld_busy, e_ld_done, e_rd_busy, e_rd_done, e_rreq, e_valid;
    logic [NB-1:0] e_wreq;
    logic [AW-1:0] e_waddr;
    logic [RAW-1:0] e_raddr;
    logic [DDR-1:0] e_wdata;
    logic hist[$];

    function automatic logic [DDR-1:0] rnd_beat();
        logic [DDR-1:0] v;
        for (int i = 0; i < DDR / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        ld_act = 0; ld_cnt = 0; ld_total = 0; ld_rows_m = 0; ld_base_m = 0;
        rd_act = 0; rd_idx = 0; rd_total = 0; rd_timer = 0; rd_base_m = 0;
        {e_ready, e_ld_busy, e_ld_done, e_rd_busy, e_rd_done, e_rreq, e_valid} = '0;
        e_wreq = '0; e_waddr = '0; e_raddr = '0; e_wdata = '0;
        hist.delete();
        for (int i = 0; i < L; i++) hist.push_back(1'b0);
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic step();
        int r, off;
        bit hold;
        if (reset) begin
            model_reset();
            return;
        end
        e_rreq = 1'b0;
        e_rd_done = 1'b0;
        if (rd_act == 1) begin
            r = (rd_base_m + rd_idx) % 256;
            hold = rd_stall;
`ifdef BIAS_BUF_CTRL_RAW_GUARD_EN
            off = (r - ld_base_m + 256) % 256;
            if (ld_act != 0 && off < ld_rows_m && ld_cnt / BPR <= off) hold = 1'b1;
`else
            off = 0;
`endif
            if (!hold) begin
                e_rreq = 1'b1;
                e_raddr = RAW'(r);
                rd_idx++;
                if (rd_idx == rd_total) begin
                    rd_act = 2;
                    rd_timer = L + 1;
                end
            end
        end else if (rd_act == 2) begin
            rd_timer--;
            if (rd_timer == 0) begin
                rd_act = 0;
                e_rd_done = 1'b1;
            end
        end else if (rd_start) begin
            if (rd_rows == 0) e_rd_done = 1'b1;
            else begin
                rd_act = 1; rd_base_m = int'(rd_base); rd_total = int'(rd_rows); rd_idx = 0;
            end
        end
        e_rd_busy = rd_act != 0;
        hist.push_back(e_rreq);
        e_valid = hist.pop_front();
        e_wreq = '0;
        e_ld_done = 1'b0;
        if (ld_act == 1) begin
            if (ddr_valid) begin
                for (int b = 0; b < NB; b++) e_wreq[b] = (b / G) == (ld_cnt % BPR);
                e_waddr = AW'((ld_base_m + ld_cnt / BPR) % 256);
                e_wdata = ddr_data;
                ld_cnt++;
                if (ld_cnt == ld_total) ld_act = 2;
            end
        end else if (ld_act == 2) begin
            ld_act = 0;
            e_ld_done = 1'b1;
        end else if (ld_start) begin
            if (ld_rows == 0) e_ld_done = 1'b1;
            else begin
                ld_act = 1; ld_base_m = int'(ld_base); ld_rows_m = int'(ld_rows);
                ld_total = int'(ld_rows) * BPR; ld_cnt = 0;
            end
        end
        e_ready = ld_act == 1;
        e_ld_busy = ld_act != 0;
    endtask

    task automatic check();
        vectors++;
        assert (ddr_ready === e_ready) else begin miscompares++; $error("FAIL ddr_ready got %0b want %0b", ddr_ready, e_ready); end
        assert (ld_busy === e_ld_busy) else begin miscompares++; $error("FAIL ld_busy got %0b want %0b", ld_busy, e_ld_busy); end
        assert (ld_done === e_ld_done) else begin miscompares++; $error("FAIL ld_done got %0b want %0b", ld_done, e_ld_done); end
        assert (rd_busy === e_rd_busy) else begin miscompares++; $error("FAIL rd_busy got %0b want %0b", rd_busy, e_rd_busy); end
        assert (rd_done === e_rd_done) else begin miscompares++; $error("FAIL rd_done got %0b want %0b", rd_done, e_rd_done); end
        assert (bias_valid === e_valid) else begin miscompares++; $error("FAIL bias_valid got %0b want %0b", bias_valid, e_valid); end
        assert (bs_write_req === e_wreq) else begin miscompares++; $error("FAIL wr_req got %h want %h", bs_write_req, e_wreq); end
        assert (bs_read_req === {NB{e_rreq}}) else begin miscompares++; $error("FAIL rd_req got %h want %0b", bs_read_req, e_rreq); end
        if (|e_wreq) begin
            assert (bs_write_data === e_wdata) else begin miscompares++; $error("FAIL wr_data got %h want %h", bs_write_data, e_wdata); end
        end
        for (int b = 0; b < NB; b++) begin
            if (e_wreq[b]) assert (bs_write_addr[b*AW +: AW] === e_waddr) else begin
                miscompares++; $error("FAIL wr_addr bank %0d got %0d want %0d", b, bs_write_addr[b*AW +: AW], e_waddr);
            end
            if (e_rreq) assert (bs_read_addr[b*RAW +: RAW] === e_raddr) else begin
                miscompares++; $error("FAIL rd_addr bank %0d got %0d want %0d", b, bs_read_addr[b*RAW +: RAW], e_raddr);
            end
        end
        if (reset) begin
            assert (bs_write_addr === '0 && bs_read_addr === '0 && bs_write_data === '0) else begin
                miscompares++; $error("FAIL reset_buses got nonzero want 0");
            end
        end
    endtask

    task automatic cycle();
        step();
        @(posedge clk);
        @(negedge clk);
        check();
    endtask

    task automatic drain(input int bound, input bit rnd_valid);
        for (int i = 0; i < bound && (ld_act != 0 || rd_act != 0); i++) begin
            ddr_data = rnd_beat();
            ddr_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
        end
        ddr_valid = 1'b0;
        assert (ld_act == 0 && rd_act == 0) else begin miscompares++; $error("FAIL drain_timeout got busy want idle"); end
        cycle();
    endtask

    initial begin
        model_reset();
        #1 reset = 1'b1;
        #1 check();
        cycle();
        cycle();
        reset = 1'b0;
        // Two-row load with valid held: four beats alternate bank groups, rows 4 then 5.
        ld_base = 8'd4; ld_rows = 9'd2; ld_start = 1'b1;
        cycle();
        ld_start = 1'b0;
        drain(40, 1'b0);
        // Single-row load with gaps: both groups land at the same address.
        ld_base = 8'd200; ld_rows = 9'd1; ld_start = 1'b1;
        cycle();
        ld_start = 1'b0;
        drain(40, 1'b1);
        // Read 10..12 with a one-cycle stall on the second issue slot.
        rd_base = 8'd10; rd_rows = 9'd3; rd_start = 1'b1;
        cycle();
        rd_start = 1'b0;
        cycle();
        rd_stall = 1'b1;
        cycle();
        rd_stall = 1'b0;
        drain(40, 1'b0);
        // Concurrent load and read on disjoint ranges.
        ld_base = 8'd20; ld_rows = 9'd3; ld_start = 1'b1;
        rd_base = 8'd100; rd_rows = 9'd4; rd_start = 1'b1;
        cycle();
        {ld_start, rd_start} = 2'b00;
        drain(80, 1'b1);
        // Overlapping ranges: reads follow load progress only when the interlock is built in.
        ld_base = 8'd50; ld_rows = 9'd3; ld_start = 1'b1;
        rd_base = 8'd49; rd_rows = 9'd4; rd_start = 1'b1;
        cycle();
        {ld_start, rd_start} = 2'b00;
        drain(80, 1'b1);
        // Reset in the middle of a load and a read.
        ld_base = 8'd7; ld_rows = 9'd4; ld_start = 1'b1;
        rd_base = 8'd30; rd_rows = 9'd5; rd_start = 1'b1;
        cycle();
        {ld_start, rd_start} = 2'b00;
        ddr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ddr_data = rnd_beat();
            cycle();
        end
        ddr_valid = 1'b0;
        #2 reset = 1'b1;
        #1 model_reset();
        check();
        cycle();
        reset = 1'b0;
        cycle();
        ld_base = 8'd9; ld_rows = 9'd1; ld_start = 1'b1;
        cycle();
        ld_start = 1'b0;
        drain(40, 1'b0);
        // Read address wrap 255 -> 0.
        rd_base = 8'd255; rd_rows = 9'd2; rd_start = 1'b1;
        cycle();
        rd_start = 1'b0;
        drain(40, 1'b0);
        // Zero-row requests pulse done next cycle.
        ld_rows = 9'd0; rd_rows = 9'd0; ld_start = 1'b1; rd_start = 1'b1;
        cycle();
        {ld_start, rd_start} = 2'b00;
        cycle();
        // Starts while busy are ignored.
        ld_base = 8'd60; ld_rows = 9'd2; rd_base = 8'd140; rd_rows = 9'd2;
        ld_start = 1'b1; rd_start = 1'b1;
        cycle();
        ld_base = 8'd0; ld_rows = 9'd5; rd_base = 8'd0; rd_rows = 9'd5;
        cycle();
        {ld_start, rd_start} = 2'b00;
        drain(80, 1'b1);
        // Random traffic on both engines.
        for (int i = 0; i < 400; i++) begin
            ld_start = $urandom_range(0, 7) == 0;
            rd_start = $urandom_range(0, 7) == 0;
            ld_base = AW'($urandom);
            rd_base = RAW'($urandom);
            ld_rows = 9'($urandom_range(0, 4));
            rd_rows = 9'($urandom_range(0, 4));
            rd_stall = $urandom_range(0, 3) == 0;
            ddr_valid = 1'($urandom_range(0, 1));
            ddr_data = rnd_beat();
            cycle();
        end
        {ld_start, rd_start, rd_stall} = 3'b000;
        drain(200, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bias_buffer_ctrl.md
Name: bias_buffer_ctrl

Overview:
Sequencer for the banked bias buffer. It has two independent engines:
- Load engine: accepts a DDR beat stream (valid/ready), slices each row across bank groups, and drives per-bank write request and address.
- Read engine: walks a programmed row range and issues lockstep reads to all banks, flagging returned bias rows with a latency-matched valid.

It sits between the DDR fetch unit/instruction decoder and the bias buffer, next to the systolic array.

Parameters:
- DDR_BANDWIDTH, 512, bits per DDR beat.
- NUM_BANKS, 64, bias buffer banks.
- WRITE_WIDTH, 8, bits written per bank per write.
- READ_WIDTH, 8, bits read per bank per read.
- WRITE_ADDR_WIDTH, 8, per-bank write address width.
- READ_ADDR_WIDTH, 8, per-bank read address width.
- READ_LATENCY_B, 1, bank read latency in cycles (≥1).
- BEATS_PER_ROW, NUM_BANKS*WRITE_WIDTH/DDR_BANDWIDTH (min 1), derived (localparam): beats that fill one row across all banks.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-high reset.
- ld_start, in, 1, pulse: begin load.
- ld_base, in, WRITE_ADDR_WIDTH, first row address for the load.
- ld_rows, in, WRITE_ADDR_WIDTH+1, number of rows to load (0 = no-op).
- ddr_valid, in, 1, DDR beat valid.
- ddr_data, in, DDR_BANDWIDTH, DDR beat.
- ddr_ready, out, 1, beat accepted when valid&ready.
- ld_busy, out, 1, load engine active.
- ld_done, out, 1, one-cycle pulse after the last write.
- rd_start, in, 1, pulse: begin read.
- rd_base, in, READ_ADDR_WIDTH, first row to read.
- rd_rows, in, READ_ADDR_WIDTH+1, number of rows to read (0 = no-op).
- rd_stall, in, 1, consumer backpressure; suppresses issue.
- rd_busy, out, 1, read engine active.
- rd_done, out, 1, one-cycle pulse when the last data returns.
- bias_valid, out, 1, bs_read_data holds a valid row this cycle.
- bs_write_req, out, NUM_BANKS, per-bank write enable.
- bs_write_addr, out, NUM_BANKS*WRITE_ADDR_WIDTH, packed per-bank write address.
- bs_write_data, out, DDR_BANDWIDTH, registered DDR beat.
- bs_read_req, out, NUM_BANKS, per-bank read enable.
- bs_read_addr, out, NUM_BANKS*READ_ADDR_WIDTH, packed per-bank read address.

Behaviour:
- Reset (async, active-high) clears all outputs to 0, both FSMs to IDLE, and all counters to 0. Reset mid-operation aborts without a done pulse. In-flight read data is discarded: the valid pipeline is cleared.
- Load FSM states IDLE→LOAD→DONE→IDLE.
  - IDLE: ddr_ready=0. On ld_start with ld_rows≠0, latch base/rows, beat=0, row=0, go to LOAD. ld_rows=0 pulses ld_done next cycle and stays IDLE.
  - LOAD: ddr_ready=1.
  - Each accepted beat registers one cycle later onto the bank group g=beat (banks g*G .. g*G+G-1, G=DDR_BANDWIDTH/WRITE_WIDTH): bs_write_req bits for that group = 1, their addresses = base+row, bs_write_data = beat. All other bits of bs_write_req are 0.
  - beat wraps at BEATS_PER_ROW-1 and then increments row.
  - After the final beat of row rows-1, go to DONE: ddr_ready=0, ld_done=1 for one cycle, then IDLE.
  - Write latency: 1 cycle from handshake to write request.
  - Row address wraps modulo 2^WRITE_ADDR_WIDTH.
  - ld_start while busy is ignored.
- Read FSM states IDLE→ISSUE→DRAIN→IDLE.
  - ISSUE: each cycle with rd_stall=0, all bs_read_req=1 and every bank address = base+idx (registered), then idx++. rd_stall=1 drives bs_read_req=0 and holds idx.
  - After the issue with idx=rows-1, go to DRAIN until the valid shift register (depth READ_LATENCY_B) empties. Then pulse rd_done and return to IDLE.
  - bias_valid = bs_read_req delayed READ_LATENCY_B cycles.
  - rd_stall does not stop data already in flight.
  - Read address wraps modulo 2^READ_ADDR_WIDTH.
  - rd_start while busy is ignored. rd_rows=0 pulses rd_done next cycle.
- The engines run concurrently; simultaneous ld_start and rd_start both take effect.
- Without the guard feature, read/write ordering is software's responsibility.

Optional Feature:
BIAS_BUF_CTRL_RAW_GUARD_EN.
- Defined: while ld_busy and the read range overlaps the load range, a read of row r is held, exactly as if rd_stall=1, until the load has completed row r, i.e. load row counter > r−ld_base (modulo compare).
- Undefined: no interlock; reads issue regardless of load progress.

Decomposition:
- Package bias_buffer_ctrl_pkg holds:
  - FSM state enums for both engines.
  - BEATS_PER_ROW and bank-group-size localparam functions.
- One natural sub-module, bias_rd_valid_pipe: a READ_LATENCY_B-deep valid shift register with clear and empty flag.

Test Plan:
- Defaults, ld_base=4, ld_rows=2, two beats with ddr_valid held → all 64 bs_write_req bits high, addr=4 then 5; data equals the beats; ld_done one cycle after the second write.
- DDR_BANDWIDTH=256, NUM_BANKS=64 (BEATS_PER_ROW=2), ld_rows=1 → beat0 writes banks 0–31 only, beat1 writes banks 32–63; both at the same address.
- rd_base=10, rd_rows=3, READ_LATENCY_B=2, rd_stall high for cycle 2 → addresses 10, (gap), 11, 12; bias_valid pattern 1,0,1,1 delayed 2 cycles; rd_done after the last valid.
- ld_start and rd_start in the same cycle on disjoint ranges → both complete independently. With BIAS_BUF_CTRL_RAW_GUARD_EN on an overlapping range, reads wait per row.
- Assert reset in the middle of a load → all outputs 0 asynchronously, no ld_done; a new load after reset release works.
- rd_base=255, rd_rows=2 → read addresses 255 then 0.
